// File: rtl/fetch_aligner_if.sv
// Fetch-aligner bus bundle: instruction-memory read port, redirect input and
// the instruction handshake to the datapath. master = aligner side.
interface fetch_aligner_if #(
  parameter int ADDR_W = 6
);
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              inst_valid;
  logic              inst_ready;
  logic [31:0]       inst_data;
  logic [31:0]       inst_pc;
  logic              inst_is_c;

  modport master (
    input  redirect, redirect_pc, imem_rdata, inst_ready,
    output imem_addr, inst_valid, inst_data, inst_pc, inst_is_c
  );

  modport slave (
    output redirect, redirect_pc, imem_rdata, inst_ready,
    input  imem_addr, inst_valid, inst_data, inst_pc, inst_is_c
  );
endinterface

// File: rtl/fetch_aligner.sv
// RV32IC fetch aligner: buffers up to three halfwords from a combinational
// word memory and issues one 16/32-bit instruction per handshake.
// Optional FETCH_ALIGN_STATS_EN adds accepted-instruction counters.
module fetch_aligner #(
  parameter int          ADDR_W   = 6,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic clk,
  input  logic rst,
`ifdef FETCH_ALIGN_STATS_EN
  output logic [31:0] stat_c_cnt,
  output logic [31:0] stat_w_cnt,
`endif
  fetch_aligner_if.master bus
);

  logic [31:0] fetch_pc, fetch_pc_n;
  logic [31:0] head_pc, head_pc_n;
  logic [47:0] hw_buf, hw_buf_n;
  logic [47:0] shifted;
  logic [1:0]  cnt, cnt_n, cnt_after, used;
  logic        skip, skip_n;
  logic        is_c, valid, take;

  always_comb begin
    is_c  = (hw_buf[1:0] != 2'b11);
    valid = (cnt >= 2'd2) || ((cnt == 2'd1) && is_c);
  end

  assign bus.inst_valid = valid;
  assign bus.inst_is_c  = valid & is_c;
  assign bus.inst_data  = is_c ? {16'h0000, hw_buf[15:0]} : hw_buf[31:0];
  assign bus.inst_pc    = head_pc;
  assign bus.imem_addr  = fetch_pc[ADDR_W+1:2];

  always_comb begin
    take = valid & bus.inst_ready;
    used = take ? (is_c ? 2'd1 : 2'd2) : 2'd0;
    case (used)
      2'd0:    shifted = hw_buf;
      2'd1:    shifted = {16'h0000, hw_buf[47:16]};
      default: shifted = {32'h0000_0000, hw_buf[47:32]};
    endcase
    cnt_after = cnt - used;

    hw_buf_n   = shifted;
    cnt_n      = cnt_after;
    fetch_pc_n = fetch_pc;
    skip_n     = skip;
    head_pc_n  = head_pc + {29'd0, used, 1'b0};

    // Refill only when at most one halfword remains, so cnt stays <= 3.
    if (cnt_after <= 2'd1) begin
      fetch_pc_n = fetch_pc + 32'd4;
      skip_n     = 1'b0;
      if (cnt_after == 2'd0) begin
        hw_buf_n = skip ? {32'h0000_0000, bus.imem_rdata[31:16]}
                        : {16'h0000, bus.imem_rdata};
        cnt_n    = skip ? 2'd1 : 2'd2;
      end else begin
        hw_buf_n = skip ? {16'h0000, bus.imem_rdata[31:16], shifted[15:0]}
                        : {bus.imem_rdata, shifted[15:0]};
        cnt_n    = skip ? 2'd2 : 2'd3;
      end
    end

    if (bus.redirect) begin
      hw_buf_n   = '0;
      cnt_n      = '0;
      head_pc_n  = {bus.redirect_pc[31:1], 1'b0};
      fetch_pc_n = {bus.redirect_pc[31:2], 2'b00};
      skip_n     = bus.redirect_pc[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= {RESET_PC[31:2], 2'b00};
      head_pc  <= RESET_PC;
      hw_buf   <= '0;
      cnt      <= '0;
      skip     <= RESET_PC[1];
    end else begin
      fetch_pc <= fetch_pc_n;
      head_pc  <= head_pc_n;
      hw_buf   <= hw_buf_n;
      cnt      <= cnt_n;
      skip     <= skip_n;
    end
  end

`ifdef FETCH_ALIGN_STATS_EN
  // Redirect does not clear these; a handshake in a redirect cycle still counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_c_cnt <= '0;
      stat_w_cnt <= '0;
    end else if (take) begin
      if (is_c) stat_c_cnt <= stat_c_cnt + 32'd1;
      else      stat_w_cnt <= stat_w_cnt + 32'd1;
    end
  end
`else
  // Statistics counters not built.
`endif

  logic unused_bits;
  assign unused_bits = ^{bus.redirect_pc[0], fetch_pc[1:0], fetch_pc[31:ADDR_W+2]};

endmodule

// File: tb/tb_fetch_aligner.sv
// Directed scoreboard bench for fetch_aligner (RESET_PC 0 and 4 instances).
module tb_fetch_aligner;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
    logic        c;
  } exp_t;

  logic clk = 1'b0;
  logic rst0, rst1;
  logic [31:0] mem [64];
  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  fetch_aligner_if #(.ADDR_W(6)) ifc0 ();
  fetch_aligner_if #(.ADDR_W(6)) ifc1 ();

`ifdef FETCH_ALIGN_STATS_EN
  logic [31:0] sc0, sw0, sc1, sw1;
`endif

  fetch_aligner #(.ADDR_W(6), .RESET_PC(32'h0000_0000)) dut0 (
    .clk(clk),
    .rst(rst0),
`ifdef FETCH_ALIGN_STATS_EN
    .stat_c_cnt(sc0),
    .stat_w_cnt(sw0),
`endif
    .bus(ifc0)
  );

  fetch_aligner #(.ADDR_W(6), .RESET_PC(32'h0000_0004)) dut1 (
    .clk(clk),
    .rst(rst1),
`ifdef FETCH_ALIGN_STATS_EN
    .stat_c_cnt(sc1),
    .stat_w_cnt(sw1),
`endif
    .bus(ifc1)
  );

  assign ifc0.imem_rdata = mem[ifc0.imem_addr];
  assign ifc1.imem_rdata = mem[ifc1.imem_addr];

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] data, input logic c);
    exp_t e;
    e.pc = pc; e.data = data; e.c = c;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (sb.size() == 0) break;
    end
    tests++;
    assert (sb.size() == 0) else begin
      fails++;
      $error("FAIL %s_timeout observed=%0d expected=0 pending", tag, sb.size());
    end
    sb.delete();
  endtask

  task automatic redirect0(input logic [31:0] pc);
    ifc0.redirect = 1'b1;
    ifc0.redirect_pc = pc;
    tick();
    ifc0.redirect = 1'b0;
  endtask

  // Scoreboard monitor: every handshake on dut0 pops one expected instruction.
  always @(negedge clk) begin
    exp_t e;
    if (!rst0 && ifc0.inst_valid && ifc0.inst_ready) begin
      tests++;
      assert (sb.size() != 0) else begin
        fails++;
        $error("FAIL sb_unexpected observed=pc %h expected=no transfer", ifc0.inst_pc);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_pc", ifc0.inst_pc, e.pc);
        chk("sb_data", ifc0.inst_data, e.data);
        chk("sb_is_c", {31'd0, ifc0.inst_is_c}, {31'd0, e.c});
      end
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0000;
    mem[0]  = 32'h00A0_0093;
    mem[1]  = 32'h0001_4505;
    mem[2]  = 32'h0093_4585;
    mem[3]  = 32'h0000_00B0;
    mem[63] = 32'h1234_0001;
    rst0 = 1'b1; rst1 = 1'b1;
    ifc0.redirect = 1'b0; ifc0.redirect_pc = '0; ifc0.inst_ready = 1'b1;
    ifc1.redirect = 1'b0; ifc1.redirect_pc = '0; ifc1.inst_ready = 1'b1;
    tick();
    tick();
    rst0 = 1'b0;

    // Sequential mixed stream from reset
    @(negedge clk);
    chk("rst_valid", {31'd0, ifc0.inst_valid}, 32'd0);
    chk("rst_pc", ifc0.inst_pc, 32'h0);
    chk("rst_data", ifc0.inst_data, 32'h0);
    chk("rst_is_c", {31'd0, ifc0.inst_is_c}, 32'd0);
    push(32'h0, 32'h00A0_0093, 1'b0);
    push(32'h4, 32'h0000_4505, 1'b1);
    push(32'h6, 32'h0000_0001, 1'b1);
    push(32'h8, 32'h0000_4585, 1'b1);
    push(32'hA, 32'h00B0_0093, 1'b0);
    @(negedge clk);
    chk("rst_latency_valid", {31'd0, ifc0.inst_valid}, 32'd1);
    drain("seq");
    ifc0.inst_ready = 1'b0;
`ifdef FETCH_ALIGN_STATS_EN
    chk("stat_c", sc0, 32'd3);
    chk("stat_w", sw0, 32'd2);
`endif

    // Redirect to 0x6 while older halfwords are buffered
    redirect0(32'h6);
    @(negedge clk);
    chk("redir_bubble_valid", {31'd0, ifc0.inst_valid}, 32'd0);
`ifdef FETCH_ALIGN_STATS_EN
    chk("stat_c_redir", sc0, 32'd3);
    chk("stat_w_redir", sw0, 32'd2);
`endif
    push(32'h6, 32'h0000_0001, 1'b1);
    push(32'h8, 32'h0000_4585, 1'b1);
    push(32'hA, 32'h00B0_0093, 1'b0);
    ifc0.inst_ready = 1'b1;
    @(negedge clk);
    chk("redir_latency_pc", ifc0.inst_pc, 32'h6);
    drain("redir6");
    ifc0.inst_ready = 1'b0;

    // Backpressure at pc 0x4
    redirect0(32'h0);
    push(32'h0, 32'h00A0_0093, 1'b0);
    ifc0.inst_ready = 1'b1;
    drain("bp_head");
    ifc0.inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, ifc0.inst_valid}, 32'd1);
      chk("bp_pc", ifc0.inst_pc, 32'h4);
      chk("bp_data", ifc0.inst_data, 32'h0000_4505);
      chk("bp_imem_addr", {26'd0, ifc0.imem_addr}, 32'd2);
    end
    tick();
    push(32'h4, 32'h0000_4505, 1'b1);
    push(32'h6, 32'h0000_0001, 1'b1);
    push(32'h8, 32'h0000_4585, 1'b1);
    push(32'hA, 32'h00B0_0093, 1'b0);
    ifc0.inst_ready = 1'b1;
    drain("bp_resume");
    ifc0.inst_ready = 1'b0;

    // Redirect and handshake in the same cycle
    redirect0(32'h0);
    tick();
    push(32'h0, 32'h00A0_0093, 1'b0);
    push(32'h8, 32'h0000_4585, 1'b1);
    push(32'hA, 32'h00B0_0093, 1'b0);
    ifc0.inst_ready = 1'b1;
    redirect0(32'h8);
    @(negedge clk);
    chk("redir_hs_bubble", {31'd0, ifc0.inst_valid}, 32'd0);
    drain("redir_hs");
    ifc0.inst_ready = 1'b0;

    // Odd redirect target: bit 0 is dropped
    redirect0(32'h5);
    tick();
    @(negedge clk);
    chk("odd_valid", {31'd0, ifc0.inst_valid}, 32'd1);
    chk("odd_pc", ifc0.inst_pc, 32'h4);
    chk("odd_data", ifc0.inst_data, 32'h0000_4505);
    chk("odd_is_c", {31'd0, ifc0.inst_is_c}, 32'd1);

    // PC wrap from the top of the address space
    tick();
    redirect0(32'hFFFF_FFFE);
    chk("wrap_imem_addr", {26'd0, ifc0.imem_addr}, 32'd63);
    push(32'hFFFF_FFFE, 32'h0000_1234, 1'b1);
    push(32'h0000_0000, 32'h00A0_0093, 1'b0);
    ifc0.inst_ready = 1'b1;
    drain("wrap");
    ifc0.inst_ready = 1'b0;

    // RESET_PC=4 instance: reset pulse in the middle of a straddle
    tick();
    rst1 = 1'b0;
    @(negedge clk);
    chk("r4_rst_valid", {31'd0, ifc1.inst_valid}, 32'd0);
    chk("r4_rst_pc", ifc1.inst_pc, 32'h4);
    @(negedge clk);
    chk("r4_pc_a", ifc1.inst_pc, 32'h4);
    chk("r4_data_a", ifc1.inst_data, 32'h0000_4505);
    @(negedge clk);
    chk("r4_pc_b", ifc1.inst_pc, 32'h6);
    @(negedge clk);
    chk("r4_pc_c", ifc1.inst_pc, 32'h8);
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    @(negedge clk);
    chk("r4_midrst_valid", {31'd0, ifc1.inst_valid}, 32'd0);
    chk("r4_midrst_pc", ifc1.inst_pc, 32'h4);
    chk("r4_midrst_data", ifc1.inst_data, 32'h0);
    @(negedge clk);
    chk("r4_after_valid", {31'd0, ifc1.inst_valid}, 32'd1);
    chk("r4_after_pc", ifc1.inst_pc, 32'h4);
    chk("r4_after_data", ifc1.inst_data, 32'h0000_4505);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
